// File: rtl/conv_maxpool_stream_if.sv
// Pooled-pixel stream: one pixel per valid/ready handshake, with its
// pooled-grid coordinates and an end-of-frame flag.
interface conv_maxpool_stream_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
) ();
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [IDX_W-1:0]  row;
   logic [IDX_W-1:0]  col;
   logic              last;

   modport master (output valid, data, row, col, last, input ready);
   modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/conv_maxpool_stream.sv
// conv_maxpool_stream: captures a flattened MAP_SIZE x MAP_SIZE signed conv
// map on the rising edge of i_valid and streams its 2x2/stride-2 max-pooled
// result, row-major, over the m_out valid/ready interface.
// Build option: define POOL_RELU_EN to clamp each pixel to max(x,0) before
// pooling. Timing is the same in both builds.
//
// state | meaning
// IDLE  | waiting for an i_valid rising edge; o_ready high
// SCAN  | map captured; walking the pooled windows and emitting pixels
module conv_maxpool_stream #(
   parameter int MAP_SIZE = 24,
   parameter int DATA_W   = 16,
   parameter int IDX_W    = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_valid,
   input  logic [MAP_SIZE*MAP_SIZE*DATA_W-1:0] i_map,
   output logic                                o_ready,
   output logic                                o_overrun,
   conv_maxpool_stream_if.master               m_out
);
   localparam int BUF_W = MAP_SIZE * MAP_SIZE * DATA_W;
   localparam int BIX_W = $clog2(BUF_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAP_SIZE / 2 - 1);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t              r_state;
   logic                r_in_valid_q;
   logic                r_ready;
   logic                r_overrun;
   logic                r_valid;
   logic                r_last;
   logic                r_all_loaded;
   logic [IDX_W-1:0]    r_pr;
   logic [IDX_W-1:0]    r_pc;
   logic [IDX_W-1:0]    r_row;
   logic [IDX_W-1:0]    r_col;
   logic [DATA_W-1:0]   r_data;
   logic [BUF_W-1:0]    r_buf;

   logic                w_edge;
   logic                w_accept;
   logic                w_hs;
   logic                w_load;
   logic                w_win_last;
   logic [BIX_W-1:0]    w_base;
   logic signed [DATA_W-1:0] w_raw [4];
   logic signed [DATA_W-1:0] w_pix [4];
   logic signed [DATA_W-1:0] w_max;

   assign w_edge     = i_valid & ~r_in_valid_q;
   assign w_accept   = w_edge & (r_state == IDLE);
   assign w_hs       = r_valid & m_out.ready;
   assign w_load     = (~r_valid | m_out.ready) & ~r_all_loaded;
   assign w_win_last = (r_pr == LAST_IDX) && (r_pc == LAST_IDX);

   // Select the 2x2 window at (r_pr, r_pc) and reduce it to its signed max.
   always_comb begin
      w_base = BIX_W'(((32'(r_pr) * 2 * MAP_SIZE) + 32'(r_pc) * 2) * DATA_W);
      w_raw[0] = r_buf[w_base +: DATA_W];
      w_raw[1] = r_buf[w_base + BIX_W'(DATA_W) +: DATA_W];
      w_raw[2] = r_buf[w_base + BIX_W'(MAP_SIZE * DATA_W) +: DATA_W];
      w_raw[3] = r_buf[w_base + BIX_W'((MAP_SIZE + 1) * DATA_W) +: DATA_W];
      for (int i = 0; i < 4; i++) begin
`ifdef POOL_RELU_EN
         w_pix[i] = w_raw[i][DATA_W-1] ? '0 : w_raw[i];
`else
         w_pix[i] = w_raw[i];
`endif
      end
      w_max = w_pix[0];
      for (int i = 1; i < 4; i++) begin
         if (w_pix[i] > w_max) w_max = w_pix[i];
      end
   end

   // Map buffer: loaded only on an accepted frame, deliberately never reset.
   always_ff @(posedge clk) begin
      if (w_accept) r_buf <= i_map;
   end

   // Frame FSM, window walker and registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_in_valid_q <= 1'b0;
         r_ready      <= 1'b1;
         r_overrun    <= 1'b0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_all_loaded <= 1'b0;
         r_pr         <= '0;
         r_pc         <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_data       <= '0;
      end else begin
         r_in_valid_q <= i_valid;
         if (w_edge && (r_state != IDLE)) r_overrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_edge) begin
                  r_state      <= SCAN;
                  r_ready      <= 1'b0;
                  r_pr         <= '0;
                  r_pc         <= '0;
                  r_all_loaded <= 1'b0;
               end
            end
            SCAN: begin
               if (w_hs && r_last) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else if (w_load) begin
                  r_valid <= 1'b1;
                  r_data  <= w_max;
                  r_row   <= r_pr;
                  r_col   <= r_pc;
                  r_last  <= w_win_last;
                  if (w_win_last) begin
                     r_all_loaded <= 1'b1;
                  end else if (r_pc == LAST_IDX) begin
                     r_pc <= '0;
                     r_pr <= r_pr + IDX_W'(1);
                  end else begin
                     r_pc <= r_pc + IDX_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign o_ready     = r_ready;
   assign o_overrun   = r_overrun;
   assign m_out.valid = r_valid;
   assign m_out.data  = r_data;
   assign m_out.row   = r_row;
   assign m_out.col   = r_col;
   assign m_out.last  = r_last;
endmodule
